// File: rtl/aegnn_pkg.sv
// Shared types and widths for the aegnn inference pipeline.
//   FC_W_WIDTH     : signed weight width of the fully-connected weight ROM
//   FC_X_WIDTH     : signed feature width entering the fully-connected stage
//   linear_state_e : control states of linear_mac_engine
package aegnn_pkg;

    localparam int FC_W_WIDTH = 8;
    localparam int FC_X_WIDTH = 8;

    typedef enum logic [1:0] {
        ACC,
        FLUSH,
        OUT
    } linear_state_e;

endpackage

// File: rtl/linear_mac_lane.sv
// One output channel of the fully-connected layer: signed multiply plus accumulator.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the accumulator (takes priority over en)
//   en       : add x*w into the accumulator this cycle
//   x, w     : signed feature and signed weight
//   acc      : signed accumulator value
module linear_mac_lane
    import aegnn_pkg::*;
#(
    parameter int ACC_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [FC_X_WIDTH-1:0] x,
    input  logic signed [FC_W_WIDTH-1:0] w,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    localparam int PROD_WIDTH = FC_X_WIDTH + FC_W_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;

    assign prod     = x * w;
    // Signed size cast sign-extends; the accumulator is wide enough that no frame overflows.
    assign prod_ext = ACC_WIDTH'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/linear_mac_engine.sv
// Fully-connected layer compute stage. Streams FC_IN_C features, reads one weight ROM row
// per accepted feature (1-cycle ROM latency) and accumulates FC_OUT_C signed dot products,
// then presents the result vector on a valid/ready output.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   s_valid/s_ready      : feature stream handshake, s_data is the signed feature
//   rd_en/w_idx          : weight ROM read enable and row index
//   fc_w                 : ROM row, lane k at fc_w[k*FC_W_WIDTH +: FC_W_WIDTH]
//   out_valid/out_ready  : result handshake
//   out_data             : lane k accumulator at out_data[k*FC_ACC_WIDTH +: FC_ACC_WIDTH]
module linear_mac_engine
    import aegnn_pkg::*;
#(
    parameter  int FC_IN_C       = 1792,
    parameter  int FC_OUT_C      = 2,
    localparam int FC_IN_C_WIDTH = $clog2(FC_IN_C),
    localparam int FC_ACC_WIDTH  = FC_W_WIDTH + FC_X_WIDTH + FC_IN_C_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [FC_X_WIDTH-1:0]            s_data,
    output logic                             rd_en,
    output logic [FC_IN_C_WIDTH-1:0]         w_idx,
    input  logic [FC_OUT_C*FC_W_WIDTH-1:0]   fc_w,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [FC_OUT_C*FC_ACC_WIDTH-1:0] out_data
);

    localparam logic [FC_IN_C_WIDTH-1:0] LAST_IDX = FC_IN_C_WIDTH'(FC_IN_C - 1);

    linear_state_e                  state;
    logic [FC_IN_C_WIDTH-1:0]       idx;
    logic signed [FC_X_WIDTH-1:0]   x_d;
    logic                           p_v;
    logic                           accept;
    logic                           clr;

    logic signed [FC_ACC_WIDTH-1:0] acc [FC_OUT_C];

    // Inputs are ignored while reset is held, so no ROM read is issued during reset.
    assign accept = s_valid & s_ready & ~rst;
    assign rd_en  = accept;
    assign w_idx  = idx;
    assign clr    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            idx       <= '0;
            x_d       <= '0;
            p_v       <= 1'b0;
            s_ready   <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            // p_v marks the cycle in which the ROM row for the previous accept arrives.
            p_v <= accept;
            if (accept) begin
                x_d <= s_data;
                idx <= (idx == LAST_IDX) ? '0 : idx + FC_IN_C_WIDTH'(1);
            end

            case (state)
                ACC: begin
                    if (accept && idx == LAST_IDX) begin
                        state   <= FLUSH;
                        s_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                        s_ready   <= 1'b1;
                    end
                end
                default: begin
                    state     <= ACC;
                    out_valid <= 1'b0;
                    s_ready   <= 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < FC_OUT_C; k++) begin : g_lane
        linear_mac_lane #(
            .ACC_WIDTH(FC_ACC_WIDTH)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (p_v),
            .x   (x_d),
            .w   (fc_w[k*FC_W_WIDTH +: FC_W_WIDTH]),
            .acc (acc[k])
        );

        assign out_data[k*FC_ACC_WIDTH +: FC_ACC_WIDTH] = acc[k];
    end

endmodule

// File: tb/tb_linear_mac_engine.sv
// Self-checking bench for linear_mac_engine with FC_IN_C=4, FC_OUT_C=2. A behavioural
// 1-cycle weight ROM stands in for linear_w_mat; its rows are loaded per test.
module tb_linear_mac_engine;
    import aegnn_pkg::*;

    localparam int IN_C = 4;
    localparam int OUT_C = 2;
    localparam int IW = 2;
    localparam int AW = FC_W_WIDTH + FC_X_WIDTH + IW;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [7:0]            s_data = '0;
    logic                  rd_en;
    logic [IW-1:0]         w_idx;
    logic [OUT_C*8-1:0]    fc_w = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [OUT_C*AW-1:0]   out_data;

    linear_mac_engine #(
        .FC_IN_C (IN_C),
        .FC_OUT_C(OUT_C)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .rd_en    (rd_en),
        .w_idx    (w_idx),
        .fc_w     (fc_w),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    // Behavioural weight ROM: 1-cycle latency, zero output when not read.
    logic [3:0][7:0] rom_w0;
    logic [3:0][7:0] rom_w1;
    always @(posedge clk) fc_w <= rd_en ? {rom_w1[w_idx], rom_w0[w_idx]} : '0;

    typedef struct {
        int l0;
        int l1;
    } res_t;

    typedef struct {
        logic [3:0][7:0] x;
        logic [3:0][7:0] w0;
        logic [3:0][7:0] w1;
        int              gap;
        int              e0;
        int              e1;
    } vec_t;

    res_t exp_q[$];
    vec_t tab[5];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc = 0;
    int last_hs = 0;
    bit have_hs = 0;
    bit cont = 0;
    bit ov_prev = 0;

    localparam logic [3:0][7:0] BASE_W0 = {8'sd5, -8'sd4, 8'sd2, 8'sd1};
    localparam logic [3:0][7:0] BASE_W1 = {8'sd1, 8'sd0, 8'sd3, -8'sd1};

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor / scoreboard, sampled 2 time units after the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (s_valid && s_ready) last_acc = cyc;
            if (out_valid && !ov_prev)
                chk(cyc - last_acc == 2, "out_valid latency", cyc - last_acc, 2);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected result", 1, 0);
                end else begin
                    res_t e;
                    longint a0, a1;
                    e  = exp_q.pop_front();
                    a0 = longint'($signed(out_data[AW-1:0]));
                    a1 = longint'($signed(out_data[2*AW-1:AW]));
                    chk(a0 == e.l0, "lane0 result", a0, e.l0);
                    chk(a1 == e.l1, "lane1 result", a1, e.l1);
                end
                if (cont && have_hs) chk(cyc - last_hs == 6, "frame period", cyc - last_hs, 6);
                last_hs = cyc;
                have_hs = 1'b1;
            end
            ov_prev = out_valid;
        end
    end

    // Present one feature at the current falling edge and hold it until accepted.
    task automatic send(input logic [7:0] x, input int idx_exp);
        int budget = 0;
        s_valid = 1'b1;
        s_data  = x;
        #1;
        while (!s_ready && budget < 50) begin
            chk(rd_en == 1'b0, "rd_en while stalled", rd_en, 0);
            @(negedge clk);
            #1;
            budget++;
        end
        chk(s_ready == 1'b1, "s_ready timeout", s_ready, 1);
        chk(rd_en == 1'b1, "rd_en on accept", rd_en, 1);
        chk(w_idx == IW'(idx_exp), "w_idx", w_idx, idx_exp);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [3:0][7:0] x, input int gap, input int e0, input int e1,
                             input bit keep);
        res_t r;
        r.l0 = e0;
        r.l1 = e1;
        exp_q.push_back(r);
        for (int i = 0; i < IN_C; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    s_valid = 1'b0;
                    #1;
                    chk(rd_en == 1'b0, "rd_en in bubble", rd_en, 0);
                    @(negedge clk);
                end
            end
            send(x[i], i);
        end
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk(exp_q.size() == 0, "drain timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tab[0] = '{x: {8'sd4, 8'sd3, 8'sd2, 8'sd1}, w0: BASE_W0, w1: BASE_W1, gap: 0,
                   e0: 13, e1: 9};
        tab[1] = '{x: {8'sd4, 8'sd3, 8'sd2, 8'sd1}, w0: BASE_W0, w1: BASE_W1, gap: 3,
                   e0: 13, e1: 9};
        tab[2] = '{x: {4{8'h80}}, w0: {4{8'h80}}, w1: {4{8'h80}}, gap: 0,
                   e0: 65536, e1: 65536};
        tab[3] = '{x: {4{8'h80}}, w0: {4{8'h7F}}, w1: {4{8'h7F}}, gap: 1,
                   e0: -65024, e1: -65024};
        tab[4] = '{x: {8'sd1, 8'sd0, 8'sd0, 8'sd0}, w0: BASE_W0, w1: BASE_W1, gap: 0,
                   e0: 5, e1: 1};
        rom_w0 = BASE_W0;
        rom_w1 = BASE_W1;

        // Reset state, with s_valid high to show it is ignored during reset.
        s_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk(out_valid == 1'b0, "reset out_valid", out_valid, 0);
        chk(s_ready == 1'b1, "reset s_ready", s_ready, 1);
        chk(rd_en == 1'b0, "reset rd_en", rd_en, 0);
        chk(w_idx == '0, "reset w_idx", w_idx, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            rom_w0 = tab[v].w0;
            rom_w1 = tab[v].w1;
            run_frame(tab[v].x, tab[v].gap, tab[v].e0, tab[v].e1, 1'b0);
            drain();
        end
        rom_w0 = BASE_W0;
        rom_w1 = BASE_W1;

        // Backpressure: result must hold while out_ready is low.
        begin
            logic [OUT_C*AW-1:0] snap;
            int budget = 0;
            out_ready = 1'b0;
            run_frame({8'sd4, 8'sd3, 8'sd2, 8'sd1}, 0, 13, 9, 1'b0);
            #1;
            while (!out_valid && budget < 20) begin
                @(negedge clk);
                #1;
                budget++;
            end
            chk(out_valid == 1'b1, "bp out_valid rise", out_valid, 1);
            snap = out_data;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                #1;
                chk(out_valid == 1'b1, "bp out_valid hold", out_valid, 1);
                chk(out_data == snap, "bp out_data stable", longint'(out_data), longint'(snap));
                chk(s_ready == 1'b0, "bp s_ready low", s_ready, 0);
            end
            @(negedge clk);
            out_ready = 1'b1;
            drain();
            run_frame({8'sd1, 8'sd0, 8'sd0, 8'sd0}, 0, 5, 1, 1'b0);
            drain();
        end

        // Mid-frame reset after two accepts.
        send(8'sd1, 0);
        send(8'sd2, 1);
        s_data = 8'sd3;
        #1 rst = 1'b1;
        #1;
        chk(out_valid == 1'b0, "midreset out_valid", out_valid, 0);
        chk(s_ready == 1'b1, "midreset s_ready", s_ready, 1);
        chk(rd_en == 1'b0, "midreset rd_en", rd_en, 0);
        chk(w_idx == '0, "midreset w_idx", w_idx, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        run_frame({8'sd4, 8'sd3, 8'sd2, 8'sd1}, 0, 13, 9, 1'b0);
        drain();

        // Continuous stream: s_valid held high across three frames.
        cont    = 1'b1;
        have_hs = 1'b0;
        run_frame({8'sd4, 8'sd3, 8'sd2, 8'sd1}, 0, 13, 9, 1'b1);
        run_frame({8'sd1, 8'sd0, 8'sd0, 8'sd0}, 0, 5, 1, 1'b1);
        run_frame({8'sd1, 8'sd2, 8'sd3, 8'sd4}, 0, 7, 6, 1'b0);
        drain();
        cont = 1'b0;

        chk(exp_q.size() == 0, "scoreboard empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
